watch_core: RTL and testbench
=============================

Name: watch_core

Overview:
- Parametrised multi-mode timekeeping core that supersedes the two-mode watch/stopwatch top.
- Holds three concurrently running functions: time-of-day watch, stopwatch, and countdown timer with an alarm flag.
- The mode FSM selects which function drives an N_DIGITS seven-segment display.
- Sits between the key_process instances (which supply short/long press pulses) and the board HEX pins.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; must be an integer multiple of TICK_HZ.
TICK_HZ, 100, stopwatch sub-second resolution; 2..100.
N_DIGITS, 4, display width; legal values 4 or 6.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_short_1  in  1  one-cycle pulse, short press of key 1
key_long_1  in  1  one-cycle pulse, long press of key 1
key_short_2  in  1  one-cycle pulse, short press of key 2
key_long_2  in  1  one-cycle pulse, long press of key 2
hex  out  7*N_DIGITS  segments, active-low, bit0=a..bit6=g per digit; digit 0 in bits [6:0] (rightmost)
mode  out  2  0=WATCH, 1=STOPWATCH, 2=TIMER
alarm  out  1  timer expired, sticky
sw_running  out  1  stopwatch counting

Behaviour:
- Reset (async assert, sync release): mode=0, alarm=0, sw_running=0, all counters 0, timer preset 00:01:00, timer state T_IDLE, every digit shows "0" (7'b1000000).
- All outputs are registered. A display reflects a state change one cycle later.
- Event priority in a cycle:
  - key_long_1 beats any short pulse; the short pulse is dropped.
  - key_short_1 and key_short_2 together: both ignored.
  - key_long_2 is ignored in all modes.
- Mode FSM: key_long_1 steps WATCH->STOPWATCH->TIMER->WATCH. No other transitions. All three functions keep running regardless of which mode is displayed.
- Watch:
  - Free-running prescaler of CLK_HZ cycles produces a second tick. Seconds 0..59, minutes 0..59, hours 0..23, with carries; 23:59:59 wraps to 00:00:00.
  - Display: HH:MM (4 digits) or HH:MM:SS (6 digits).
  - In WATCH mode, key_short_1 increments hours (23->0, no other field changes).
  - In WATCH mode, key_short_2 increments minutes (59->0, no carry) and clears seconds and the prescaler.
- Stopwatch:
  - Own prescaler of CLK_HZ/TICK_HZ cycles, cleared on start. The first sub-tick lands exactly CLK_HZ/TICK_HZ cycles after the start pulse.
  - Fraction 0..TICK_HZ-1 is shown as 2 BCD digits, with seconds and minutes above it.
  - Display: SS:ff (4 digits) or MM:SS:ff (6 digits).
  - Wraps to zero past 59:(TICK_HZ-1) (4 digits) or 59:59:(TICK_HZ-1) (6 digits).
  - In STOPWATCH mode, key_short_2 toggles run/stop.
  - In STOPWATCH mode, key_short_1 clears to zero only while stopped; it is ignored while running.
- Timer:
  - FSM states T_IDLE, T_RUN, T_PAUSE, T_DONE.
  - Display: MM:SS (4 digits) or HH:MM:SS (6 digits). In T_IDLE it shows the preset; otherwise it shows the remaining time.
  - T_IDLE: key_short_1 adds one minute to the preset; minutes wrap 99->0 (4 digits) or 59->0 with hour carry, hours 23->0 (6 digits).
  - T_IDLE: key_short_2 loads remaining=preset, clears the timer prescaler and enters T_RUN. It is ignored if the preset is zero.
  - T_RUN: each CLK_HZ cycles remaining decrements by one second. When remaining reaches zero, the state becomes T_DONE and alarm=1, both on the same clock edge.
  - T_RUN: key_short_2 enters T_PAUSE, and the prescaler holds its value.
  - T_PAUSE: key_short_2 returns to T_RUN, resuming the prescaler.
  - T_PAUSE: key_short_1 returns to T_IDLE; remaining is discarded.
  - T_DONE: either short key enters T_IDLE and clears alarm.
  - Key actions apply only in TIMER mode. Alarm persists across mode changes.
- BCD math: each field is kept as tens/units digits; there is no binary-to-BCD conversion. A shared 4-bit-to-7-seg decoder is applied per digit.
- Reset mid-operation: everything returns to reset values immediately, including any pending prescaler counts.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=10, N_DIGITS=4 unless stated.
1. Reset, then 60_000 cycles idle -> hex digits 0,0,0,1 (watch 00:01); mode=0, alarm=0. Assert rst_n low mid-count -> hex returns to all 7'b1000000 with no clock edge.
2. key_long_1 three times -> mode 1,2,0. key_long_1 plus key_short_1 in the same cycle in WATCH -> mode advances, hours unchanged.
3. STOPWATCH: key_short_2, wait 1550 cycles -> display 01:05, sw_running=1. key_short_1 while running -> no change. key_short_2 then key_short_1 -> 00:00.
4. TIMER: key_short_1 once -> preset 02:00. key_short_2, wait 1000 cycles -> 01:59. key_short_2 (pause), wait 5000 cycles -> still 01:59. key_short_1 -> T_IDLE showing 02:00.
5. TIMER expiry: preset 01:00, start, wait 60_000 cycles -> display 00:00, alarm=1. Switch to WATCH -> alarm stays 1. Return to TIMER, key_short_2 -> alarm=0, display 01:00.
6. WATCH set: key_short_1 ×24 -> hours back to 00. At minutes=59, key_short_2 -> minutes 00 with hours unchanged. Repeat scenario 1 with N_DIGITS=6 -> HH:MM:SS shows 00:01:00.

Source files
------------

// File: rtl/watch_core.sv
// watch_core: time-of-day watch, stopwatch and countdown timer running side by
// side. A mode FSM picks which one drives the N_DIGITS seven-segment display.
// All fields are kept as BCD tens/units pairs, so the display never needs a
// binary-to-BCD conversion.
module watch_core #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 100,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_short_1,
    input  logic                  key_long_1,
    input  logic                  key_short_2,
    input  logic                  key_long_2,
    output logic [7*N_DIGITS-1:0] hex,
    output logic [1:0]            mode,
    output logic                  alarm,
    output logic                  sw_running
);

    localparam bit SIX    = (N_DIGITS == 6);
    localparam int SW_DIV = CLK_HZ / TICK_HZ;
    localparam int WW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SWW    = (SW_DIV > 1) ? $clog2(SW_DIV) : 1;
    localparam int DW     = 4 * N_DIGITS;

    localparam logic [WW-1:0]  W_MAX  = WW'(CLK_HZ - 1);
    localparam logic [SWW-1:0] S_MAX  = SWW'(SW_DIV - 1);
    // Largest stopwatch fraction, as BCD tens/units
    localparam logic [7:0]     F_MAX  = {4'((TICK_HZ - 1) / 10), 4'((TICK_HZ - 1) % 10)};
    // Timer minutes run to 99 when hours are not displayed
    localparam logic [7:0]     T_MMAX = SIX ? 8'h59 : 8'h99;

    typedef enum logic [1:0] {M_WATCH = 2'd0, M_STOP = 2'd1, M_TIMER = 2'd2} mode_e;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_RUN = 2'd1, T_PAUSE = 2'd2, T_DONE = 2'd3} tstate_e;

    // BCD pair increment with wrap to zero after max
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max)             r = 8'h00;
        else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
        else                      r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // BCD pair decrement with wrap from zero to max
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == 8'h00)           r = max;
        else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
        else                      r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // Active-low segments, bit0 = a .. bit6 = g; non-decimal codes blank
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    mode_e   mode_q, mode_d;
    tstate_e t_st_q, t_st_d;

    logic [WW-1:0]  w_pre_q, w_pre_d;
    logic [7:0]     w_s_q, w_s_d, w_m_q, w_m_d, w_h_q, w_h_d;

    logic [SWW-1:0] s_pre_q, s_pre_d;
    logic [7:0]     s_f_q, s_f_d, s_s_q, s_s_d, s_m_q, s_m_d;
    logic           s_run_q, s_run_d;

    logic [WW-1:0]  t_pre_q, t_pre_d;
    logic [7:0]     p_m_q, p_m_d, p_h_q, p_h_d;
    logic [7:0]     r_s_q, r_s_d, r_m_q, r_m_d, r_h_q, r_h_d;
    logic           alarm_q, alarm_d;

    logic [7*N_DIGITS-1:0] hex_q, hex_d;

    // key_long_2 has no function in any mode
    logic unused_long_2;
    assign unused_long_2 = key_long_2;

    // A long press swallows any short press; two shorts together cancel
    logic ev_l1, ev_s1, ev_s2;
    assign ev_l1 = key_long_1;
    assign ev_s1 = key_short_1 & ~key_short_2 & ~key_long_1;
    assign ev_s2 = key_short_2 & ~key_short_1 & ~key_long_1;

    logic in_w, in_s, in_t;
    assign in_w = (mode_q == M_WATCH);
    assign in_s = (mode_q == M_STOP);
    assign in_t = (mode_q == M_TIMER);

    // Mode FSM: long press of key 1 cycles WATCH -> STOPWATCH -> TIMER
    always_comb begin
        mode_d = mode_q;
        if (ev_l1) begin
            case (mode_q)
                M_WATCH: mode_d = M_STOP;
                M_STOP:  mode_d = M_TIMER;
                default: mode_d = M_WATCH;
            endcase
        end
    end

    // Watch: one-second prescaler, HH:MM:SS carry chain, hour/minute setting
    always_comb begin
        w_s_d   = w_s_q;
        w_m_d   = w_m_q;
        w_h_d   = w_h_q;
        w_pre_d = w_pre_q + WW'(1);
        if (w_pre_q == W_MAX) begin
            w_pre_d = '0;
            w_s_d   = bcd_inc(w_s_q, 8'h59);
            if (w_s_q == 8'h59) begin
                w_m_d = bcd_inc(w_m_q, 8'h59);
                if (w_m_q == 8'h59) w_h_d = bcd_inc(w_h_q, 8'h23);
            end
        end
        if (in_w && ev_s1) begin
            w_h_d = bcd_inc(w_h_q, 8'h23);
        end else if (in_w && ev_s2) begin
            // Setting minutes restarts the current minute from :00
            w_m_d   = bcd_inc(w_m_q, 8'h59);
            w_h_d   = w_h_q;
            w_s_d   = 8'h00;
            w_pre_d = '0;
        end
    end

    // Stopwatch: sub-second prescaler, fraction/seconds/minutes, start/stop/clear
    always_comb begin
        s_run_d = s_run_q;
        s_pre_d = s_pre_q;
        s_f_d   = s_f_q;
        s_s_d   = s_s_q;
        s_m_d   = s_m_q;
        if (s_run_q) begin
            if (s_pre_q == S_MAX) begin
                s_pre_d = '0;
                s_f_d   = bcd_inc(s_f_q, F_MAX);
                if (s_f_q == F_MAX) begin
                    s_s_d = bcd_inc(s_s_q, 8'h59);
                    // Minutes are only kept when they are shown
                    if (SIX && s_s_q == 8'h59) s_m_d = bcd_inc(s_m_q, 8'h59);
                end
            end else begin
                s_pre_d = s_pre_q + SWW'(1);
            end
        end
        if (in_s && ev_s2) begin
            s_run_d = ~s_run_q;
            // Starting restarts the prescaler so the first sub-tick is a full period away
            if (!s_run_q) s_pre_d = '0;
        end else if (in_s && ev_s1 && !s_run_q) begin
            s_pre_d = '0;
            s_f_d   = 8'h00;
            s_s_d   = 8'h00;
            s_m_d   = 8'h00;
        end
    end

    // Timer FSM: preset editing, countdown, pause and sticky alarm
    always_comb begin
        t_st_d  = t_st_q;
        t_pre_d = t_pre_q;
        p_m_d   = p_m_q;
        p_h_d   = p_h_q;
        r_s_d   = r_s_q;
        r_m_d   = r_m_q;
        r_h_d   = r_h_q;
        alarm_d = alarm_q;
        case (t_st_q)
            T_IDLE: begin
                if (in_t && ev_s1) begin
                    p_m_d = bcd_inc(p_m_q, T_MMAX);
                    if (SIX && p_m_q == 8'h59) p_h_d = bcd_inc(p_h_q, 8'h23);
                end else if (in_t && ev_s2 && (p_m_q != 8'h00 || p_h_q != 8'h00)) begin
                    r_h_d   = p_h_q;
                    r_m_d   = p_m_q;
                    r_s_d   = 8'h00;
                    t_pre_d = '0;
                    t_st_d  = T_RUN;
                end
            end
            T_RUN: begin
                if (in_t && ev_s2) begin
                    t_st_d = T_PAUSE;
                end else if (t_pre_q == W_MAX) begin
                    t_pre_d = '0;
                    if ({r_h_q, r_m_q, r_s_q} == 24'h000001) begin
                        r_s_d   = 8'h00;
                        t_st_d  = T_DONE;
                        alarm_d = 1'b1;
                    end else begin
                        r_s_d = bcd_dec(r_s_q, 8'h59);
                        if (r_s_q == 8'h00) begin
                            r_m_d = bcd_dec(r_m_q, T_MMAX);
                            if (SIX && r_m_q == 8'h00) r_h_d = bcd_dec(r_h_q, 8'h23);
                        end
                    end
                end else begin
                    t_pre_d = t_pre_q + WW'(1);
                end
            end
            T_PAUSE: begin
                if (in_t && ev_s2) begin
                    t_st_d = T_RUN;
                end else if (in_t && ev_s1) begin
                    t_st_d = T_IDLE;
                    r_s_d  = 8'h00;
                    r_m_d  = 8'h00;
                    r_h_d  = 8'h00;
                end
            end
            default: begin
                if (in_t && (ev_s1 || ev_s2)) begin
                    t_st_d  = T_IDLE;
                    alarm_d = 1'b0;
                end
            end
        endcase
    end

    // Display mux: pick the active function's digits and decode each one
    logic [23:0]   w_word, s_word, t_word, sel_word;
    logic [DW-1:0] disp;
    always_comb begin
        w_word = SIX ? {w_h_q, w_m_q, w_s_q} : {8'h00, w_h_q, w_m_q};
        s_word = SIX ? {s_m_q, s_s_q, s_f_q} : {8'h00, s_s_q, s_f_q};
        if (t_st_q == T_IDLE) t_word = SIX ? {p_h_q, p_m_q, 8'h00} : {8'h00, p_m_q, 8'h00};
        else                  t_word = SIX ? {r_h_q, r_m_q, r_s_q} : {8'h00, r_m_q, r_s_q};
        case (mode_q)
            M_STOP:  sel_word = s_word;
            M_TIMER: sel_word = t_word;
            default: sel_word = w_word;
        endcase
        disp  = DW'(sel_word);
        hex_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            hex_d[7*i +: 7] = seg7(disp[4*i +: 4]);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= M_WATCH;
            w_pre_q <= '0;
            w_s_q   <= 8'h00;
            w_m_q   <= 8'h00;
            w_h_q   <= 8'h00;
            s_pre_q <= '0;
            s_f_q   <= 8'h00;
            s_s_q   <= 8'h00;
            s_m_q   <= 8'h00;
            s_run_q <= 1'b0;
            t_st_q  <= T_IDLE;
            t_pre_q <= '0;
            p_m_q   <= 8'h01;
            p_h_q   <= 8'h00;
            r_s_q   <= 8'h00;
            r_m_q   <= 8'h00;
            r_h_q   <= 8'h00;
            alarm_q <= 1'b0;
            hex_q   <= {N_DIGITS{7'b1000000}};
        end else begin
            mode_q  <= mode_d;
            w_pre_q <= w_pre_d;
            w_s_q   <= w_s_d;
            w_m_q   <= w_m_d;
            w_h_q   <= w_h_d;
            s_pre_q <= s_pre_d;
            s_f_q   <= s_f_d;
            s_s_q   <= s_s_d;
            s_m_q   <= s_m_d;
            s_run_q <= s_run_d;
            t_st_q  <= t_st_d;
            t_pre_q <= t_pre_d;
            p_m_q   <= p_m_d;
            p_h_q   <= p_h_d;
            r_s_q   <= r_s_d;
            r_m_q   <= r_m_d;
            r_h_q   <= r_h_d;
            alarm_q <= alarm_d;
            hex_q   <= hex_d;
        end
    end

    assign hex        = hex_q;
    assign mode       = mode_q;
    assign alarm      = alarm_q;
    assign sw_running = s_run_q;

endmodule

// File: tb/tb_watch_core.sv
// Directed bench for watch_core: a 4-digit instance driven through a table of
// key/wait/expect rows, plus an idle 6-digit instance checked for HH:MM:SS.
module tb_watch_core;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 10;

    // Key bit positions inside a table row
    localparam logic [3:0] K_S1 = 4'b0001;
    localparam logic [3:0] K_L1 = 4'b0010;
    localparam logic [3:0] K_S2 = 4'b0100;
    localparam logic [3:0] K_L2 = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ks1 = 1'b0, kl1 = 1'b0, ks2 = 1'b0, kl2 = 1'b0;
    logic        k6_idle = 1'b0;

    logic [27:0] hex4;
    logic [1:0]  mode4;
    logic        alarm4, swr4;
    logic [41:0] hex6;
    logic [1:0]  mode6;
    logic        alarm6, swr6;

    watch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .key_short_1(ks1), .key_long_1(kl1), .key_short_2(ks2), .key_long_2(kl2),
        .hex(hex4), .mode(mode4), .alarm(alarm4), .sw_running(swr4)
    );

    watch_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_DIGITS(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .key_short_1(k6_idle), .key_long_1(k6_idle), .key_short_2(k6_idle), .key_long_2(k6_idle),
        .hex(hex6), .mode(mode6), .alarm(alarm6), .sw_running(swr6)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  keys;
        int          reps;
        int          waits;
        logic [15:0] dig;
        logic [1:0]  mode;
        logic        alarm;
        logic        swr;
        logic        chk6;
        logic [23:0] dig6;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h40; 4'd1: s = 7'h79; 4'd2: s = 7'h24; 4'd3: s = 7'h30;
            4'd4: s = 7'h19; 4'd5: s = 7'h12; 4'd6: s = 7'h02; 4'd7: s = 7'h78;
            4'd8: s = 7'h00; 4'd9: s = 7'h10; default: s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [27:0] hex_of4(input logic [15:0] dig);
        logic [27:0] h;
        for (int i = 0; i < 4; i++) h[7*i +: 7] = seg(dig[4*i +: 4]);
        return h;
    endfunction

    function automatic logic [41:0] hex_of6(input logic [23:0] dig);
        logic [41:0] h;
        for (int i = 0; i < 6; i++) h[7*i +: 7] = seg(dig[4*i +: 4]);
        return h;
    endfunction

    task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] keys, input int reps, input int waits,
                       input logic [15:0] dig, input logic [1:0] md, input logic alm,
                       input logic swr, input logic chk6, input logic [23:0] dig6);
        vec_t v;
        v.keys = keys; v.reps = reps; v.waits = waits; v.dig = dig; v.mode = md;
        v.alarm = alm; v.swr = swr; v.chk6 = chk6; v.dig6 = dig6;
        vecs.push_back(v);
    endtask

    task automatic drive_keys(input logic [3:0] k);
        {kl2, ks2, kl1, ks1} = k;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each row: hold keys for reps edges, idle waits edges, then compare.
        // Edge numbers in comments count from reset release.
        add(K_L1, 1, 0,     16'h0000, 2'd1, 0, 0, 0, 24'h0);   // e1 mode STOP
        add(K_L1, 1, 0,     16'h0000, 2'd2, 0, 0, 0, 24'h0);   // e2 mode TIMER
        add(K_S2, 1, 0,     16'h0100, 2'd2, 0, 0, 0, 24'h0);   // e3 timer starts at 01:00
        add(K_L1, 1, 0,     16'h0100, 2'd0, 0, 0, 0, 24'h0);   // e4 back to WATCH
        add(4'h0, 1, 59996, 16'h0001, 2'd0, 0, 0, 1, 24'h000100); // e60001 watch 00:01
        add(4'h0, 1, 0,     16'h0001, 2'd0, 0, 0, 0, 24'h0);   // e60002 one before expiry
        add(4'h0, 1, 0,     16'h0001, 2'd0, 1, 0, 0, 24'h0);   // e60003 alarm rises
        add(K_L1, 1, 0,     16'h0001, 2'd1, 1, 0, 0, 24'h0);
        add(K_L1, 1, 0,     16'h0000, 2'd2, 1, 0, 0, 24'h0);
        add(4'h0, 1, 0,     16'h0000, 2'd2, 1, 0, 0, 24'h0);   // timer shows 00:00
        add(K_L1, 1, 0,     16'h0000, 2'd0, 1, 0, 0, 24'h0);   // alarm kept in WATCH
        add(K_L1, 1, 0,     16'h0001, 2'd1, 1, 0, 0, 24'h0);
        add(K_L1, 1, 0,     16'h0000, 2'd2, 1, 0, 0, 24'h0);
        add(K_S2, 1, 0,     16'h0000, 2'd2, 0, 0, 0, 24'h0);   // acknowledge alarm
        add(4'h0, 1, 0,     16'h0100, 2'd2, 0, 0, 0, 24'h0);   // idle shows preset
        add(K_S1, 1, 0,     16'h0100, 2'd2, 0, 0, 0, 24'h0);
        add(4'h0, 1, 0,     16'h0200, 2'd2, 0, 0, 0, 24'h0);   // preset 02:00
        add(K_S2, 1, 1000,  16'h0200, 2'd2, 0, 0, 0, 24'h0);   // tick lands, not yet shown
        add(4'h0, 1, 0,     16'h0159, 2'd2, 0, 0, 0, 24'h0);   // 01:59
        add(K_S2, 1, 5000,  16'h0159, 2'd2, 0, 0, 0, 24'h0);   // paused
        add(K_S1, 1, 1,     16'h0200, 2'd2, 0, 0, 0, 24'h0);   // back to idle
        add(K_L1, 1, 0,     16'h0200, 2'd0, 0, 0, 0, 24'h0);
        add(K_L1, 1, 0,     16'h0001, 2'd1, 0, 0, 0, 24'h0);   // STOPWATCH
        add(K_S2, 1, 100,   16'h0000, 2'd1, 0, 1, 0, 24'h0);   // first sub-tick not yet shown
        add(4'h0, 1, 0,     16'h0001, 2'd1, 0, 1, 0, 24'h0);
        add(4'h0, 1, 1448,  16'h0105, 2'd1, 0, 1, 0, 24'h0);   // 1550 cycles: 01:05
        add(K_S1, 1, 1,     16'h0105, 2'd1, 0, 1, 0, 24'h0);   // clear ignored while running
        add(K_S2, 1, 0,     16'h0105, 2'd1, 0, 0, 0, 24'h0);   // stop
        add(K_S1, 1, 1,     16'h0000, 2'd1, 0, 0, 0, 24'h0);   // clear
        add(K_L1, 1, 0,     16'h0000, 2'd2, 0, 0, 0, 24'h0);
        add(K_L1, 1, 1,     16'h0001, 2'd0, 0, 0, 0, 24'h0);   // WATCH 00:01
        add(K_S1, 1, 1,     16'h0101, 2'd0, 0, 0, 0, 24'h0);
        add(K_S1, 23, 1,    16'h0001, 2'd0, 0, 0, 0, 24'h0);   // 24 presses wrap hours
        add(K_S1, 5, 1,     16'h0501, 2'd0, 0, 0, 0, 24'h0);
        add(K_S2, 58, 1,    16'h0559, 2'd0, 0, 0, 0, 24'h0);
        add(K_S2, 1, 1,     16'h0500, 2'd0, 0, 0, 0, 24'h0);   // 59 -> 00, no hour carry
        add(K_S1 | K_S2, 1, 1, 16'h0500, 2'd0, 0, 0, 0, 24'h0); // both shorts ignored
        add(K_L1 | K_S1, 1, 0, 16'h0500, 2'd1, 0, 0, 0, 24'h0); // long wins, hours kept
        add(K_L1, 2, 1,     16'h0500, 2'd0, 0, 0, 0, 24'h0);
        add(K_L2, 1, 1,     16'h0500, 2'd0, 0, 0, 0, 24'h0);   // long key 2 does nothing

        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset hex4",  64'(hex4),  64'(hex_of4(16'h0000)));
        chk("reset hex6",  64'(hex6),  64'(hex_of6(24'h000000)));
        chk("reset mode",  64'(mode4), 64'(2'd0));
        chk("reset alarm", 64'(alarm4), 64'(1'b0));
        chk("reset swrun", 64'(swr4),  64'(1'b0));
        chk("reset mode6", 64'({mode6, alarm6, swr6}), 64'(4'h0));

        // Table-driven body
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive_keys(vecs[i].keys);
                step();
            end
            drive_keys(4'h0);
            for (int w = 0; w < vecs[i].waits; w++) step();
            chk($sformatf("row%0d hex", i),   64'(hex4),   64'(hex_of4(vecs[i].dig)));
            chk($sformatf("row%0d mode", i),  64'(mode4),  64'(vecs[i].mode));
            chk($sformatf("row%0d alarm", i), 64'(alarm4), 64'(vecs[i].alarm));
            chk($sformatf("row%0d swrun", i), 64'(swr4),   64'(vecs[i].swr));
            if (vecs[i].chk6) chk($sformatf("row%0d hex6", i), 64'(hex6), 64'(hex_of6(vecs[i].dig6)));
        end

        // Asynchronous reset between clock edges
        rst_n = 1'b0;
        #2;
        chk("async hex4", 64'(hex4),  64'(hex_of4(16'h0000)));
        chk("async hex6", 64'(hex6),  64'(hex_of6(24'h000000)));
        chk("async mode", 64'(mode4), 64'(2'd0));
        step();
        rst_n = 1'b1;

        // Timer preset returns to 01:00 after reset
        drive_keys(K_L1);
        step();
        step();
        drive_keys(4'h0);
        step();
        chk("preset after reset", 64'(hex4), 64'(hex_of4(16'h0100)));
        chk("mode after reset",   64'(mode4), 64'(2'd2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
